// File: rtl/user_rx_checker_pkg.sv
// Shared types and helpers for the NWRITE payload checker: FSM encoding,
// default payload seed and the last-beat byte-enable mask.
package user_rx_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [63:0] SEED_DEFAULT = 64'hBC00_0000_0000_0000;
    localparam int          TSIZE_W      = 20;
    localparam int          ADDR_W       = 34;
    // One bit wider than the largest beat count so an overrunning packet
    // still compares correctly against exp_beats.
    localparam int          BEAT_W       = 21;

    // Left-aligned keep for a last beat carrying r bytes (r = 0 means full).
    function automatic logic [7:0] keep_mask(input logic [2:0] rem);
        return (rem == 3'd0) ? 8'hFF : 8'(8'hFF << (4'd8 - {1'b0, rem}));
    endfunction

    // ((tsize + 1) + 7) >> 3, i.e. qwords needed for tsize+1 bytes.
    function automatic logic [BEAT_W-1:0] calc_exp_beats(input logic [TSIZE_W-1:0] tsize);
        logic [BEAT_W-1:0] nbytes_rnd;
        nbytes_rnd = BEAT_W'(tsize) + BEAT_W'(8);
        return nbytes_rnd >> 3;
    endfunction

endpackage

// File: rtl/user_rx_checker_beat_chk.sv
// Combinational per-beat checker: compares one accepted beat against the
// expected qword, packet position, expected length and last-beat keep.
module user_rx_beat_chk
    import user_rx_checker_pkg::*;
(
    input  logic [63:0]       tdata,
    input  logic [63:0]       exp_data,
    input  logic [7:0]        tkeep,
    input  logic              tfirst,
    input  logic              tlast,
    input  logic [BEAT_W-1:0] beat_idx,
    input  logic [BEAT_W-1:0] exp_beats,
    input  logic [2:0]        rem,
    output logic              data_err,
    output logic              first_err,
    output logic              len_err,
    output logic              keep_err
);

    logic [BEAT_W-1:0] beat_num;

    assign beat_num  = beat_idx + BEAT_W'(1);
    assign data_err  = (tdata != exp_data);
    assign first_err = (beat_idx == '0) ? ~tfirst : tfirst;
    // Early tlast, or a missing tlast exactly on the expected final beat.
    assign len_err   = tlast ? (beat_num < exp_beats) : (beat_num == exp_beats);
    assign keep_err  = tlast ? (tkeep != keep_mask(rem)) : (tkeep != 8'hFF);

endmodule

// File: rtl/user_rx_checker.sv
// Inbound NWRITE payload checker: verifies a SEED+n qword pattern, framing,
// length and byte enables per packet, and keeps saturating statistics.
module user_rx_checker
    import user_rx_checker_pkg::*;
#(
    parameter logic [63:0] SEED  = SEED_DEFAULT,
    parameter int          CNT_W = 16
) (
    input  logic               log_clk,
    input  logic               log_rst_n,
    input  logic               user_tvalid_in,
    output logic               user_tready_o,
    input  logic [63:0]        user_tdata_in,
    input  logic [7:0]         user_tkeep_in,
    input  logic               user_tfirst_in,
    input  logic               user_tlast_in,
    input  logic [TSIZE_W-1:0] user_tsize_in,
    input  logic [ADDR_W-1:0]  user_addr_in,
    output logic               pkt_done_o,
    output logic               pkt_err_o,
    output logic               err_sticky_o,
    input  logic               err_clr_in,
    output logic [CNT_W-1:0]   pkt_cnt_o,
    output logic [CNT_W-1:0]   err_cnt_o,
    output logic [ADDR_W-1:0]  last_addr_o
);

    state_e            state_q, state_d;
    logic              tready_q, tready_d;
    logic [BEAT_W-1:0] exp_beats_q, exp_beats_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [2:0]        rem_q, rem_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic              perr_q, perr_d;
    logic              sticky_q, sticky_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;

    logic              hs;
    logic              in_idle;
    logic [BEAT_W-1:0] cur_idx;
    logic [BEAT_W-1:0] cur_exp_beats;
    logic [2:0]        cur_rem;
    logic [63:0]       exp_data;
    logic              data_err, first_err, len_err, keep_err, beat_err;
    logic [CNT_W-1:0]  pkt_base, err_base;

    assign hs      = user_tvalid_in & tready_q;
    assign in_idle = (state_q == ST_IDLE);

    // The first beat is checked against the live tsize; later beats use the
    // values captured from it.
    assign cur_idx       = in_idle ? '0 : beat_cnt_q;
    assign cur_exp_beats = in_idle ? calc_exp_beats(user_tsize_in) : exp_beats_q;
    assign cur_rem       = in_idle ? 3'(user_tsize_in[2:0] + 3'd1) : rem_q;
    assign exp_data      = SEED + 64'(cur_idx);

    user_rx_beat_chk u_beat_chk (
        .tdata     (user_tdata_in),
        .exp_data  (exp_data),
        .tkeep     (user_tkeep_in),
        .tfirst    (user_tfirst_in),
        .tlast     (user_tlast_in),
        .beat_idx  (cur_idx),
        .exp_beats (cur_exp_beats),
        .rem       (cur_rem),
        .data_err  (data_err),
        .first_err (first_err),
        .len_err   (len_err),
        .keep_err  (keep_err)
    );

    assign beat_err = data_err | first_err | len_err | keep_err;

    // A clear coincident with DONE zeroes first, then the packet is counted.
    assign pkt_base = err_clr_in ? '0 : pkt_cnt_q;
    assign err_base = err_clr_in ? '0 : err_cnt_q;

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        exp_beats_d = exp_beats_q;
        beat_cnt_d  = beat_cnt_q;
        rem_d       = rem_q;
        err_d       = err_q;
        last_addr_d = last_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (hs) begin
                    exp_beats_d = cur_exp_beats;
                    rem_d       = cur_rem;
                    last_addr_d = user_addr_in;
                    beat_cnt_d  = BEAT_W'(1);
                    err_d       = beat_err;
                    state_d     = user_tlast_in ? ST_DONE : ST_RECV;
                end
            end
            ST_RECV: begin
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    err_d      = err_q | beat_err;
                    if (user_tlast_in) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        tready_d = (state_d != ST_DONE);
        done_d   = (state_d == ST_DONE);
        perr_d   = (state_d == ST_DONE) & err_d;

        pkt_cnt_d = pkt_base;
        err_cnt_d = err_base;
        if (state_q == ST_DONE) begin
            if (pkt_base != '1) begin
                pkt_cnt_d = pkt_base + CNT_W'(1);
            end
            if (err_q && (err_base != '1)) begin
                err_cnt_d = err_base + CNT_W'(1);
            end
        end

        sticky_d = (sticky_q & ~err_clr_in) | (hs & beat_err) | ((state_q == ST_DONE) & err_q);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state_q     <= ST_IDLE;
            tready_q    <= 1'b0;
            exp_beats_q <= '0;
            beat_cnt_q  <= '0;
            rem_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
            sticky_q    <= 1'b0;
            pkt_cnt_q   <= '0;
            err_cnt_q   <= '0;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            exp_beats_q <= exp_beats_d;
            beat_cnt_q  <= beat_cnt_d;
            rem_q       <= rem_d;
            err_q       <= err_d;
            done_q      <= done_d;
            perr_q      <= perr_d;
            sticky_q    <= sticky_d;
            pkt_cnt_q   <= pkt_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign user_tready_o = tready_q;
    assign pkt_done_o    = done_q;
    assign pkt_err_o     = perr_q;
    assign err_sticky_o  = sticky_q;
    assign pkt_cnt_o     = pkt_cnt_q;
    assign err_cnt_o     = err_cnt_q;
    assign last_addr_o   = last_addr_q;

endmodule

// File: doc/user_rx_checker.md
USER_RX_CHECKER -- requirements
Module: user_rx_checker

Interface
REQ-001 Parameter SEED, 64'hBC00_0000_0000_0000, expected payload of the first qword of every packet.
REQ-002 Parameter CNT_W, 16, width of packet and error counters.
REQ-003 log_clk  input  1  sole clock; all logic on rising edge.
REQ-004 log_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 user_tvalid_in  input  1  inbound NWRITE payload beat valid.
REQ-006 user_tready_o  output  1  beat accept; a beat transfers when tvalid and tready are both high.
REQ-007 user_tdata_in  input  64  payload qword.
REQ-008 user_tkeep_in  input  8  byte enables, left-aligned (bit 7 = first byte).
REQ-009 user_tfirst_in  input  1  first beat of packet.
REQ-010 user_tlast_in  input  1  last beat of packet.
REQ-011 user_tsize_in  input  20  packet byte count minus 1, valid on the first beat.
REQ-012 user_addr_in  input  34  target address, valid on the first beat, captured only.
REQ-013 pkt_done_o  output  1  one-cycle pulse per completed packet.
REQ-014 pkt_err_o  output  1  one-cycle pulse with pkt_done_o when the packet had any error.
REQ-015 err_sticky_o  output  1  set by any error, held until err_clr_in.
REQ-016 err_clr_in  input  1  synchronous clear of err_sticky_o and both counters.
REQ-017 pkt_cnt_o  output  CNT_W  completed packets, saturating.
REQ-018 err_cnt_o  output  CNT_W  errored packets, saturating.
REQ-019 last_addr_o  output  34  address of the most recent packet.

Function
REQ-020 The FSM SHALL have states IDLE, RECV and DONE; tready = 1 in IDLE and RECV, 0 in DONE.
REQ-021 IDLE: on a handshake, capture tsize/addr, set exp_beats = ((tsize+1)+7)>>3, check beat 1, go to RECV (or to DONE if tlast).
REQ-022 RECV: each handshake increments qword count and checks the beat; tlast moves to DONE.
REQ-023 DONE SHALL last exactly one cycle, pulse pkt_done_o and pkt_err_o, update the counters, and return to IDLE.
REQ-024 The expected data for beat n (n from 0) SHALL be SEED+n (modulo 2^64) and SHALL restart at SEED for each packet.
REQ-025 Data error: tdata differs from the expected value.
REQ-026 First error: user_tfirst_in is low on the first beat, or high on a later beat.
REQ-027 Length error: tlast arrives before exp_beats, or is absent on beat exp_beats; on overrun, reception continues until tlast.
REQ-028 Keep error: keep is not 8'hFF on non-last beats; on the last beat, with r=(tsize+1) mod 8, keep SHALL equal 8'hFF if r=0, else 8'hFF<<(8-r).
REQ-029 Per-packet error flag SHALL OR all errors and clear on entry to IDLE.
REQ-030 Counters SHALL saturate at all-ones; err_clr_in coincident with DONE SHALL clear, then count the current packet (the new event wins).
REQ-031 Beats with tvalid low SHALL be ignored; gaps of any length are legal.

Reset
REQ-032 On log_rst_n low, from any state including mid-packet: state = IDLE, all outputs and counters = 0, tready = 0 during reset and 1 on the first cycle after release.

Structure
REQ-033 The shared package SHALL hold the state encoding, the SEED default and a tkeep-mask function.
REQ-034 One sub-module, user_rx_beat_chk, SHALL be combinational: it takes the expected qword, beat index, exp_beats and r, and returns the four error bits.

Verification
REQ-035 tsize=255 (32 beats), correct pattern, keep FF -> 1 pkt_done_o pulse, pkt_err_o=0, pkt_cnt_o=1, tready low for exactly 1 cycle after the last beat.
REQ-036 tsize=4 (5 bytes, 1 beat, tfirst+tlast, keep F8) -> pkt_done_o, no error; keep FC on the same packet -> pkt_err_o=1, err_cnt_o=1.
REQ-037 Beat 7 data = SEED+8 -> pkt_err_o=1 at end, err_sticky_o=1 until err_clr_in.
REQ-038 tsize=255 with tlast on beat 31 -> length error; tlast on beat 33 -> length error, 33 beats accepted, one done pulse.
REQ-039 log_rst_n asserted at beat 10 of 32 -> all outputs 0; the next full packet passes with pkt_cnt_o=1.
REQ-040 pkt_cnt_o preloaded to near saturation (CNT_W=4, 16 packets sent) -> holds 4'hF; err_clr_in with DONE -> count = 1.
